// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and IF/ID register with boot, stall, redirect and sticky fault
module fetch_unit #(
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter logic [31:0] TEXT_LAST = 32'h0040_4000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_instruction,
    input  logic [31:0] start_addr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_addr,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pc_bad;

    assign fetch_addr = pc;

    // A wrapped pc lands below TEXT_BASE, so the range check also covers overflow.
    assign pc_bad = (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || (pc > TEXT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= TEXT_BASE;
            if_id_valid    <= 1'b0;
            if_id_instr    <= 32'd0;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            fetch_fault    <= 1'b0;
            fault_pc       <= 32'd0;
        end else begin
            case (state)
                BOOT: begin
                    pc    <= start_addr;
                    state <= RUN;
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc          <= redirect_target;
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'd0;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (pc_bad) begin
                        fault_pc    <= pc;
                        fetch_fault <= 1'b1;
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'd0;
                        state       <= FAULT;
                    end else begin
                        if_id_instr    <= mem_instruction;
                        if_id_pc       <= pc;
                        if_id_pc_plus4 <= pc + 32'd4;
                        if_id_valid    <= 1'b1;
                        pc             <= pc + 32'd4;
                    end
                end
                FAULT: begin
                    pc <= pc;
                end
                default: begin
                    state <= BOOT;
                    pc    <= TEXT_BASE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a behavioural model
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] LAST = 32'h0040_4000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_instruction;
    logic [31:0] start_addr = 32'h0040_0010;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] fetch_addr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: "booting" and "faulted" flags rather than a state encoding.
    bit          m_booting;
    bit          m_faulted;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_fault_pc;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .mem_instruction (mem_instruction),
        .start_addr      (start_addr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_addr      (fetch_addr),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .fetch_fault     (fetch_fault),
        .fault_pc        (fault_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5679;
    endfunction

    assign mem_instruction = mem_word(fetch_addr);

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && (a <= LAST);
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_booting = 1; m_faulted = 0; m_pc = BASE;
            m_valid = 0; m_instr = 0; m_ipc = 0; m_fault_pc = 0;
        end else if (m_booting) begin
            m_pc = start_addr;
            m_booting = 0;
        end else if (m_faulted) begin
        end else if (redirect_valid) begin
            m_pc = redirect_target; m_valid = 0; m_instr = 0;
        end else if (stall) begin
        end else if (!addr_ok(m_pc)) begin
            m_fault_pc = m_pc; m_faulted = 1; m_valid = 0; m_instr = 0;
        end else begin
            m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fetch_addr"}, fetch_addr, m_pc);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        chk({tag, ".instr"}, if_id_instr, m_instr);
        chk({tag, ".pc"}, if_id_pc, m_ipc);
        chk({tag, ".pc_plus4"}, if_id_pc_plus4, (m_ipc == 0 && !m_valid && m_instr == 0 && if_id_pc == 0) ? 32'd0 : m_ipc + 32'd4);
        chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, m_faulted});
        chk({tag, ".fault_pc"}, fault_pc, m_fault_pc);
    endtask

    task automatic cycle(input string tag, input bit rst, input bit stl, input bit rv, input logic [31:0] tgt);
        reset = rst; stall = stl; redirect_valid = rv; redirect_target = tgt;
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_target();
        int r = $urandom_range(0, 9);
        if (r < 7) return BASE + ($urandom_range(0, 4096) << 2);
        if (r == 7) return BASE + ($urandom_range(0, 4096) << 2) + $urandom_range(1, 3);
        if (r == 8) return BASE - ($urandom_range(1, 64) << 2);
        return LAST + ($urandom_range(1, 64) << 2);
    endfunction

    logic [31:0] saved_instr;

    initial begin
        // Boot: reset held 2 cycles
        start_addr = 32'h0040_0010;
        cycle("rst0", 1, 0, 0, 0);
        cycle("rst1", 1, 1, 1, 32'h0040_0200);
        chk("reset_fetch_addr", fetch_addr, 32'h0040_0000);
        chk("reset_pc_plus4", if_id_pc_plus4, 32'd0);
        cycle("boot", 0, 1, 1, 32'h0040_0200);
        chk("boot_fetch_addr", fetch_addr, 32'h0040_0010);
        chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
        cycle("first", 0, 0, 0, 0);
        chk("first_pc", if_id_pc, 32'h0040_0010);
        chk("first_pc4", if_id_pc_plus4, 32'h0040_0014);
        chk("first_instr", if_id_instr, mem_word(32'h0040_0010));

        // Sequential then stall
        cycle("seq1", 0, 0, 0, 0);
        cycle("seq2", 0, 0, 0, 0);
        saved_instr = if_id_instr;
        cycle("stall1", 0, 1, 0, 0);
        cycle("stall2", 0, 1, 0, 0);
        chk("stall_hold_instr", if_id_instr, saved_instr);
        chk("stall_hold_addr", fetch_addr, 32'h0040_001C);
        cycle("resume", 0, 0, 0, 0);
        chk("resume_pc", if_id_pc, 32'h0040_001C);

        // Redirect with simultaneous stall
        cycle("redir", 0, 1, 1, 32'h0040_0100);
        chk("redir_addr", fetch_addr, 32'h0040_0100);
        chk("redir_instr", if_id_instr, 32'd0);
        cycle("redir_fetch", 0, 0, 0, 0);
        chk("redir_latch", if_id_instr, mem_word(32'h0040_0100));

        // Misaligned redirect
        cycle("misal", 0, 0, 1, 32'h0040_0102);
        cycle("misal_fault", 0, 0, 0, 0);
        chk("misal_fault_pc", fault_pc, 32'h0040_0102);
        chk("misal_fault_flag", {31'd0, fetch_fault}, 32'd1);
        cycle("fault_redir", 0, 0, 1, 32'h0040_0200);
        cycle("fault_hold", 0, 1, 0, 0);
        chk("fault_sticky_addr", fetch_addr, 32'h0040_0102);

        // Reset in FAULT, then run into TEXT_LAST overrun
        start_addr = LAST - 8;
        cycle("rst_fault", 1, 1, 0, 0);
        chk("rst_fault_flag", {31'd0, fetch_fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        cycle("boot2", 0, 0, 0, 0);
        cycle("ovr1", 0, 0, 0, 0);
        cycle("ovr2", 0, 0, 0, 0);
        cycle("ovr3", 0, 0, 0, 0);
        chk("last_word_pc", if_id_pc, LAST);
        chk("last_word_valid", {31'd0, if_id_valid}, 32'd1);
        cycle("ovr4", 0, 0, 0, 0);
        chk("overrun_fault_pc", fault_pc, LAST + 4);

        // Reset while stalled
        start_addr = 32'h0040_0040;
        cycle("rst2", 1, 0, 0, 0);
        cycle("boot3", 0, 0, 0, 0);
        cycle("run3", 0, 0, 0, 0);
        cycle("stall3", 0, 1, 0, 0);
        cycle("rst_stall", 1, 1, 0, 0);
        chk("rst_stall_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_stall_addr", fetch_addr, BASE);
        cycle("boot4", 0, 0, 0, 0);
        cycle("run4", 0, 0, 0, 0);
        chk("reboot_pc", if_id_pc, 32'h0040_0040);

        // Wrapping start address faults via range check
        start_addr = 32'hFFFF_FFFC;
        cycle("rst_wrap", 1, 0, 0, 0);
        cycle("boot_wrap", 0, 0, 0, 0);
        cycle("wrap_fault", 0, 0, 0, 0);
        chk("wrap_fault_pc", fault_pc, 32'hFFFF_FFFC);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit rst = ($urandom_range(0, 49) == 0);
            bit stl = ($urandom_range(0, 3) == 0);
            bit rv  = ($urandom_range(0, 9) == 0);
            if (rst) start_addr = rand_target();
            cycle("rand", rst, stl, rv, rand_target());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and IF/ID pipeline-register stage sitting directly upstream of the fetch instruction memory.
- Drives the memory's byte read address and boots from the memory's start-address word.
- Latches each returned instruction into the IF/ID register for decode.
- Handles stalls, branch/jump redirects from later stages, and a sticky fault state for misaligned or out-of-range PCs.

Parameters:
- TEXT_BASE, 32'h0040_0000, lowest valid fetch byte address; PC value held during BOOT.
- TEXT_LAST, 32'h0040_4000, highest valid word-aligned fetch byte address, inclusive.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- mem_instruction  in  32  combinational instruction word returned by memory for fetch_addr.
- start_addr  in  32  program entry byte address from memory word at TEXT_BASE.
- stall  in  1  hazard stall from decode; hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  32  byte address to fetch next when redirect_valid=1.
- fetch_addr  out  32  byte read address to memory; equals pc combinationally.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  latched instruction; 0 (nop) when invalid.
- if_id_pc  out  32  address of latched instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4, modulo 2^32.
- fetch_fault  out  1  sticky; PC was misaligned or outside [TEXT_BASE, TEXT_LAST].
- fault_pc  out  32  offending PC, captured on fault entry.

Behaviour:
- States: BOOT, RUN, FAULT.
- Reset (synchronous, any state, including mid-stall or mid-fault):
  - state=BOOT, pc=TEXT_BASE.
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0.
  - fetch_fault=0, fault_pc=0.
- BOOT:
  - Lasts exactly one cycle after reset deasserts; covers memory's zero-output first cycle.
  - pc<=start_addr, IF/ID stays invalid, then state<=RUN.
  - stall and redirect are ignored in BOOT.
- RUN: priority per cycle is redirect > stall > fault check > normal advance.
  - Redirect (redirect_valid=1):
    - pc<=redirect_target.
    - IF/ID <= bubble (valid=0, instr=0, pc fields hold).
    - Applies even if stall=1. No fault check this cycle.
  - Stall (stall=1, no redirect): pc and all IF/ID outputs hold.
  - Fault check (no stall, no redirect): triggers if pc[1:0]!=0, pc<TEXT_BASE, or pc>TEXT_LAST.
    - fault_pc<=pc, fetch_fault<=1, IF/ID<=bubble, state<=FAULT.
  - Normal advance:
    - if_id_instr<=mem_instruction, if_id_pc<=pc, if_id_pc_plus4<=pc+4, if_id_valid<=1.
    - pc<=pc+4.
- Fetch-to-IF/ID latency is 1 cycle. First valid instruction appears 2 cycles after reset deasserts (BOOT + first RUN fetch).
- Bad redirect targets and bad start_addr values are caught one cycle later, on the RUN cycle that would fetch them.
- Sequential overrun past TEXT_LAST faults on the fetch of TEXT_LAST+4. The TEXT_LAST word itself is fetched normally.
- FAULT:
  - pc, fault_pc and fetch_fault hold; IF/ID stays bubble.
  - stall and redirect are ignored. Exit only via reset.
- Arithmetic: 32-bit unsigned; pc+4 wraps at 2^32. A wrapped pc faults via the range check.
- fetch_addr is always pc, in every state.

Test Plan:
- Boot:
  - Stimulus: start_addr=0x0040_0010; hold reset 2 cycles, release.
  - Response: fetch_addr=0x0040_0000 during BOOT, then 0x0040_0010. IF/ID valid the following cycle with if_id_pc=0x0040_0010, if_id_pc_plus4=0x0040_0014, instr equal to the memory word.
- Sequential and stall:
  - Stimulus: 3 fetches, then stall=1 for 2 cycles.
  - Response: fetch_addr and all IF/ID outputs frozen for both stall cycles. Advance resumes at the next address with no skipped or duplicated instruction.
- Redirect:
  - Stimulus: redirect_valid=1, target=0x0040_0100, with stall=1 simultaneously.
  - Response: next fetch_addr=0x0040_0100, if_id_valid=0, if_id_instr=0. The following cycle latches the word at 0x0040_0100.
- Misaligned redirect:
  - Stimulus: redirect target=0x0040_0102.
  - Response: one cycle later fetch_fault=1, fault_pc=0x0040_0102, if_id_valid=0. Stays faulted despite further redirects.
- Range overrun:
  - Stimulus: pc reaches TEXT_LAST=0x0040_4000.
  - Response: word at 0x0040_4000 latched valid. Next cycle fetch_fault=1, fault_pc=0x0040_4004.
- Reset mid-operation:
  - Stimulus: assert reset while in FAULT, and separately while stalled.
  - Response: next edge gives all outputs at reset values and state=BOOT. A normal boot sequence follows.
